// File: rtl/pwm_audio_pkg.sv
// Shared audio word layout and demodulator state encoding for the PWM audio path.
// Latency: n/a (types, constants and a pure packing function only).
// Backpressure: n/a.
package pwm_audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;
  localparam int AUD_MSB  = 27;
  localparam int AUD_LSB  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // Place a 16-bit 2's-complement sample in the audio field; all other bits zero.
  function automatic logic [WORD_W-1:0] pack_aud_sample(input logic [SAMPLE_W-1:0] s);
    logic [WORD_W-1:0] w;
    w = '0;
    w[AUD_MSB:AUD_LSB] = s;
    return w;
  endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry register FIFO presenting its head entry on a valid/ready stream.
// Latency: a push into an empty FIFO is visible on the output the next cycle.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module axis_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         pop,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   count;
  logic         accept;

  assign valid  = (count != 2'd0);
  assign full   = (count == 2'd2);
  assign pop    = valid && ready;
  assign accept = push && (!full || pop);
  assign data   = head;

  // Storage update: head is always the oldest entry, tail the second one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({pop, accept})
        2'b10: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b01: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pwm_demodulator.sv
// Recovers audio samples from a 1-bit PWM/PDM input by counting highs per frame.
// Latency: sample visible the cycle after its frame ends (FIFO empty); input sync adds SYNC_STAGES.
// Backpressure: 2-entry output FIFO; samples arriving while it is full are dropped and counted.
module pwm_demodulator
  import pwm_audio_pkg::*;
#(
  parameter int         FRAME_LOG2  = 7,
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] CHANNEL_ID  = 3'd0
) (
  input  logic        m_axis_aud_aclk,
  input  logic        m_axis_aud_areset,
  input  logic        pwm_in,
  input  logic        enable,
  output logic        m_axis_aud_tvalid,
  input  logic        m_axis_aud_tready,
  output logic [31:0] m_axis_aud_tdata,
  output logic [2:0]  m_axis_aud_tid,
  output logic [15:0] overrun_cnt,
  output logic        locked
);

  localparam int CNT_W = FRAME_LOG2;
  localparam int SHIFT = SAMPLE_W - FRAME_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  logic                   clk;
  logic                   rst;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_d;
  logic                   rise;
  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       frame_cnt;
  logic [CNT_W:0]         acc;
  logic [CNT_W:0]         count_final;
  logic [SAMPLE_W:0]      u_wide;
  logic [SAMPLE_W-1:0]    u_sat;
  logic [SAMPLE_W-1:0]    sample;
  logic                   frame_end;
  logic                   fifo_full;
  logic                   fifo_pop;

  assign clk = m_axis_aud_aclk;
  assign rst = m_axis_aud_areset;

  // Input synchroniser plus one extra delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d  <= pwm_s;
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: dropping enable always returns to IDLE, abandoning the frame.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ALIGN;
        ALIGN:   if (rise) state_nxt = ACCUM;
        ACCUM:   state_nxt = ACCUM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: lock indication and the frame-end strobe (suppressed by a disable).
  always_comb begin
    locked    = 1'b0;
    frame_end = 1'b0;
    if (state == ACCUM) begin
      locked    = 1'b1;
      frame_end = enable && (frame_cnt == CNT_LAST);
    end
  end

  // Frame counter and high-cycle accumulator; the aligning cycle counts as the first high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      acc       <= '0;
    end else if (!enable || state == IDLE) begin
      frame_cnt <= '0;
      acc       <= '0;
    end else if (state == ALIGN) begin
      if (rise) begin
        frame_cnt <= CNT_W'(1);
        acc       <= (CNT_W+1)'(1);
      end
    end else begin
      frame_cnt <= frame_cnt + CNT_W'(1);
      acc       <= frame_end ? '0 : acc + (CNT_W+1)'(pwm_s);
    end
  end

  // Count to 2's-complement: scale to 16 bits, clamp the full-scale count, flip the MSB.
  always_comb begin
    count_final = acc + (CNT_W+1)'(pwm_s);
    u_wide      = (SAMPLE_W+1)'(count_final) << SHIFT;
    u_sat       = u_wide[SAMPLE_W] ? {SAMPLE_W{1'b1}} : u_wide[SAMPLE_W-1:0];
    sample      = {~u_sat[SAMPLE_W-1], u_sat[SAMPLE_W-2:0]};
  end

  // Saturating count of samples refused by a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (frame_end && fifo_full && !fifo_pop && overrun_cnt != 16'hFFFF) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

  axis_fifo2 #(
    .W (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (frame_end),
    .push_data (pack_aud_sample(sample)),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .valid     (m_axis_aud_tvalid),
    .ready     (m_axis_aud_tready),
    .data      (m_axis_aud_tdata)
  );

  assign m_axis_aud_tid = CHANNEL_ID;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Directed bench for pwm_demodulator at FRAME_LOG2=7, SYNC_STAGES=2, CHANNEL_ID=0.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_demodulator;

  localparam int FRAME = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic        enable = 1'b0;
  logic        tvalid;
  logic        tready = 1'b0;
  logic [31:0] tdata;
  logic [2:0]  tid;
  logic [15:0] overrun_cnt;
  logic        locked;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [31:0] got_q[$];
  int          got_cyc[$];
  logic [2:0]  got_tid[$];

  typedef struct {
    int          highs;
    logic [15:0] s;
  } vec_t;

  vec_t vecs[9];

  pwm_demodulator #(
    .FRAME_LOG2  (7),
    .SYNC_STAGES (2),
    .CHANNEL_ID  (3'd0)
  ) dut (
    .m_axis_aud_aclk   (clk),
    .m_axis_aud_areset (rst),
    .pwm_in            (pwm_in),
    .enable            (enable),
    .m_axis_aud_tvalid (tvalid),
    .m_axis_aud_tready (tready),
    .m_axis_aud_tdata  (tdata),
    .m_axis_aud_tid    (tid),
    .overrun_cnt       (overrun_cnt),
    .locked            (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Record every completed handshake, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      got_q.push_back(tdata);
      got_cyc.push_back(cycle);
      got_tid.push_back(tid);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One input frame: high for the first `highs` cycles, low for the rest.
  task automatic drive_frame(input int highs);
    for (int i = 0; i < FRAME; i++) begin
      pwm_in = (i < highs);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_capture();
    got_q.delete();
    got_cyc.delete();
    got_tid.delete();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;
    tready = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    clear_capture();
  endtask

  function automatic logic [31:0] word_of(input logic [15:0] s);
    return {4'b0, s, 12'b0};
  endfunction

  initial begin
    vecs[0] = '{1,   16'h8200};
    vecs[1] = '{128, 16'h7FFF};
    vecs[2] = '{64,  16'h0000};
    vecs[3] = '{0,   16'h8000};
    vecs[4] = '{32,  16'hC000};
    vecs[5] = '{96,  16'h4000};
    vecs[6] = '{127, 16'h7E00};
    vecs[7] = '{100, 16'h4800};
    vecs[8] = '{64,  16'h0000};

    // Reset state while reset is held.
    #2;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_tid", 32'(tid), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);

    // Table-driven stream with tready held high.
    do_reset();
    tready = 1'b1;
    enable = 1'b1;
    cycles(4);
    check("align_not_locked", 32'(locked), 32'd0);
    foreach (vecs[k]) drive_frame(vecs[k].highs);
    pwm_in = 1'b0;
    check("stream_locked", 32'(locked), 32'd1);
    cycles(10);
    check("stream_count", got_q.size(), 9);
    for (int k = 0; k < 9; k++) begin
      if (k < got_q.size()) begin
        check($sformatf("stream_data[%0d]", k), got_q[k], word_of(vecs[k].s));
        check($sformatf("stream_tid[%0d]", k), 32'(got_tid[k]), 32'd0);
        if (k > 0) check($sformatf("stream_gap[%0d]", k), got_cyc[k] - got_cyc[k-1], FRAME);
      end
    end
    enable = 1'b0;
    cycles(1);
    check("disable_unlocks", 32'(locked), 32'd0);

    // Backpressure: five frames into a stalled output.
    do_reset();
    enable = 1'b1;
    cycles(3);
    drive_frame(1);
    drive_frame(128);
    drive_frame(64);
    check("bp_head_f3", tdata, 32'h08200000);
    drive_frame(32);
    drive_frame(0);
    cycles(6);
    enable = 1'b0;
    cycles(2);
    check("bp_overrun", 32'(overrun_cnt), 32'd3);
    check("bp_tvalid", 32'(tvalid), 32'd1);
    check("bp_head_f5", tdata, 32'h08200000);
    clear_capture();
    tready = 1'b1;
    cycles(5);
    check("bp_drain_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("bp_drain0", got_q[0], 32'h08200000);
      check("bp_drain1", got_q[1], 32'h07FFF000);
    end
    check("bp_empty", 32'(tvalid), 32'd0);

    // Enable drop mid-frame with one sample still queued.
    do_reset();
    enable = 1'b1;
    cycles(3);
    drive_frame(128);
    for (int i = 0; i < 60; i++) begin
      pwm_in = 1'b1;
      cycles(1);
    end
    enable = 1'b0;
    cycles(1);
    check("drop_locked", 32'(locked), 32'd0);
    cycles(200);
    check("drop_queued_valid", 32'(tvalid), 32'd1);
    check("drop_queued_data", tdata, 32'h07FFF000);
    check("drop_overrun", 32'(overrun_cnt), 32'd0);
    clear_capture();
    tready = 1'b1;
    cycles(3);
    check("drop_drain_count", got_q.size(), 1);
    if (got_q.size() >= 1) check("drop_drain_data", got_q[0], 32'h07FFF000);
    check("drop_empty", 32'(tvalid), 32'd0);
    enable = 1'b1;
    cycles(150);
    check("realign_wait", 32'(locked), 32'd0);
    check("realign_no_sample", got_q.size(), 1);
    pwm_in = 1'b0;
    cycles(2);
    pwm_in = 1'b1;
    cycles(5);
    check("realign_locked", 32'(locked), 32'd1);
    enable = 1'b0;

    // Asynchronous reset with one queued sample and two overruns.
    do_reset();
    enable = 1'b1;
    cycles(3);
    drive_frame(1);
    drive_frame(128);
    drive_frame(64);
    drive_frame(0);
    cycles(6);
    enable = 1'b0;
    cycles(2);
    tready = 1'b1;
    cycles(1);
    tready = 1'b0;
    cycles(1);
    check("pre_rst_overrun", 32'(overrun_cnt), 32'd2);
    check("pre_rst_valid", 32'(tvalid), 32'd1);
    check("pre_rst_head", tdata, 32'h07FFF000);
    enable = 1'b1;
    cycles(3);
    for (int i = 0; i < 40; i++) begin
      pwm_in = (i < 20);
      cycles(1);
    end
    check("pre_rst_locked", 32'(locked), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_tvalid", 32'(tvalid), 32'd0);
    check("async_tdata", tdata, 32'd0);
    check("async_overrun", 32'(overrun_cnt), 32'd0);
    check("async_locked", 32'(locked), 32'd0);
    pwm_in = 1'b0;
    @(posedge clk);
    #1;
    cycles(2);
    rst = 1'b0;
    clear_capture();
    tready = 1'b1;
    cycles(3);
    drive_frame(32);
    pwm_in = 1'b0;
    check("post_rst_none_yet", got_q.size(), 0);
    cycles(6);
    check("post_rst_count", got_q.size(), 1);
    if (got_q.size() >= 1) check("post_rst_data", got_q[0], 32'h0C000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_demodulator.md
# pwm_demodulator

Receive-side counterpart of the audio PWM modulator: recovers audio samples from a 1-bit PWM (or PDM) input and emits them on an AXI4-Stream audio master interface. The block synchronises the input, counts high cycles over fixed power-of-two frames, and converts each count to 2's-complement audio. It places each sample in the 24-bit audio field of a 32-bit word. It sits between a comparator/PDM pad and the audio stream fabric, for loopback testing and capture.

## Interface
- FRAME_LOG2, 7: log2 of clock cycles per sample frame; legal range 4..16.
- SYNC_STAGES, 2: flip-flop stages on `pwm_in`; minimum 2.
- CHANNEL_ID, 3'd0: constant driven on `m_axis_aud_tid`.
- `m_axis_aud_aclk` in 1: the single clock.
- `m_axis_aud_areset` in 1: asynchronous, active-high reset.
- `pwm_in` in 1: asynchronous PWM/PDM input.
- `enable` in 1: synchronous run enable.
- `m_axis_aud_tvalid` out 1: sample available.
- `m_axis_aud_tready` in 1: downstream accepts.
- `m_axis_aud_tdata` out 32: sample word.
- `m_axis_aud_tid` out 3: channel id.
- `overrun_cnt` out 16: saturating count of dropped samples.
- `locked` out 1: high while in ACCUM.

## Operation
- **Synchroniser:** `pwm_in` passes through SYNC_STAGES flops to give `pwm_s`. A one-flop delayed copy, `pwm_d`, drives rising-edge detection: `rise = pwm_s & ~pwm_d`.
- **State machine:**
  - IDLE (reset state): acc=0, frame_cnt=0. Goes to ALIGN when `enable`=1.
  - ALIGN: waits for `rise`, then goes to ACCUM. On that same edge, frame_cnt=1 and acc=1.
  - ACCUM: each cycle, frame_cnt increments and acc += `pwm_s`.
  - Any state goes to IDLE when `enable`=0. A partial frame is discarded.
- **Frame end:** occurs in ACCUM when frame_cnt == 2^FRAME_LOG2-1.
  - Final count c = acc + `pwm_s`, range 0..2^FRAME_LOG2.
  - Both counters wrap to 0, and the converted sample is pushed to the FIFO.
  - The frame that starts on the next cycle is counted from frame_cnt=0.
- **Conversion:**
  - u = c << (16-FRAME_LOG2), computed in 17 bits and saturated to 16'hFFFF.
  - s = {~u[15], u[14:0]}.
  - `tdata` = {4'b0, s, 12'b0}, i.e. s sits in bits [27:12]; bits [11:0] and [31:28] are zero.
- **Output buffer:** a 2-entry FIFO.
  - `tvalid` = not empty. `tdata` and `tid` come from the head entry and are stable while `tvalid` && !`tready`.
  - Push when full: the new sample is dropped and `overrun_cnt` increments, saturating at 16'hFFFF. FIFO contents are untouched.
  - If a push and a pop occur in the same cycle while full, the push is accepted.
- **Disable:** `enable`=0 does not flush the FIFO; queued samples still drain.
- **Reset values:** `tvalid`=0, `tdata`=0, `tid`=CHANNEL_ID, `overrun_cnt`=0, `locked`=0, FIFO empty, state IDLE, synchroniser flops 0.

## Timing
- `pwm_in` to `pwm_s`: SYNC_STAGES cycles.
- ALIGN exits on the clock edge where `rise`=1, i.e. SYNC_STAGES+1 edges after the input rising edge.
- Frame end edge to `tvalid`=1: the sample is visible in the cycle right after the frame end edge, when the FIFO was empty.
- Sample throughput: one sample per 2^FRAME_LOG2 cycles.
- A handshake completes on an edge where `tvalid` && `tready` both hold. The next entry, if any, is presented in the following cycle.
- `enable` deassertion takes effect on the next edge. The frame in flight is lost, no sample is produced, and `locked` falls on that edge.
- Reset asserted mid-frame or mid-handshake: all state clears immediately (asynchronous). Release is synchronous to the clock.

## Structure
- **Package `pwm_audio_pkg`:**
  - Types and constants: `SAMPLE_W`=16, `AUD_MSB`=27, `AUD_LSB`=12, state enum {IDLE, ALIGN, ACCUM}.
  - Function `pack_aud_sample(s)` that returns the 32-bit word. The modulator reuses the same bit positions for unpacking.
- **Sub-module `axis_fifo2`:** a 2-entry AXIS FIFO with push/full/pop, parameterised width. Register-based; no RAM.
- Synchroniser, FSM, accumulator and converter are inline in `pwm_demodulator`.

## Test plan
- **Constant high:** `pwm_in`=1 from reset, plus one 0→1 edge to align. Every sample has `tdata`[27:12]=16'h7FFF and `tdata`=32'h07FFF000.
- **Constant low after one edge:** pwm held 1 for 1 cycle at align, then 0. The first frame gives c=1, so s=16'h8200 at FRAME_LOG2=7. Later samples are 16'h8000.
- **50% duty, period 128, aligned:** every sample is 16'h0000 with `tid`=CHANNEL_ID. `tvalid` rises 1 cycle after each frame end; spacing is exactly 128 cycles.
- **Backpressure:** `tready`=0 for 5 frames. The FIFO holds the first 2 samples unchanged and `overrun_cnt`=3. Raising `tready` drains the 2 originals in order, then `tvalid`=0.
- **Enable drop:** `enable`=0 at frame_cnt=60. No sample is produced, `locked`=0, and a queued sample still drains. Re-enable waits in ALIGN for the next `rise`.
- **Mid-operation reset:** assert reset with 1 queued sample and `overrun_cnt`=2. Outputs go to reset values asynchronously, and nothing is emitted until a new full frame completes.
